ps2_scancode_rx: RTL

- PS/2 keyboard receiver. It deserializes device-to-host frames from the keyboard pins.
- It folds the 0xE0 (extended) and 0xF0 (break) prefix bytes into one 16-bit code word.
- It pulses newchar once per complete key event.
- It is the producer side of the newchar/char[15:0] interface consumed by the data memory's keyboard mailbox. That consumer ignores words whose upper byte is 0xF0.

---
 rtl/ps2_scancode_rx_if.sv | 17 +
 rtl/ps2_scancode_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx_if.sv
// -----------------------------------------------------------------------------
// ps2_scancode_rx_if
// Key-event bus from the PS/2 receiver to the keyboard mailbox.
//   newchar   : one-clk pulse, char holds a new complete key event
//   char      : [15:8] prefix (F0 break, E0 extended make, 00 plain make),
//               [7:0] scancode; holds its value between pulses
//   frame_err : one-clk pulse when a frame is discarded
// Modports: master = receiver (drives), slave = mailbox (observes).
// -----------------------------------------------------------------------------
interface ps2_scancode_rx_if;
   logic        newchar;
   logic [15:0] char;
   logic        frame_err;

   modport master (output newchar, output char, output frame_err);
   modport slave  (input  newchar, input  char, input  frame_err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// ps2_scancode_rx
// PS/2 keyboard receiver. Deserializes 11-bit device-to-host frames
// (start, d0..d7 LSB first, odd parity, stop) and folds the E0 (extended)
// and F0 (break) prefix bytes into a single 16-bit key-event word.
//
// Parameters:
//   TIMEOUT_CYCLES : clk cycles without a ps2_clk fall before a partial
//                    frame is aborted
//   SYNC_STAGES    : synchronizer depth on both pins (2..3)
// Ports:
//   clk      : system clock, all state on the rising edge
//   rst_n    : asynchronous assert, active-low reset
//   ps2_clk  : raw PS/2 clock pin (asynchronous, idles high)
//   ps2_data : raw PS/2 data pin (asynchronous, idles high)
//   kb       : key-event bus (newchar / char / frame_err), master side
// -----------------------------------------------------------------------------
module ps2_scancode_rx #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ps2_clk,
   input  logic                      ps2_data,
   ps2_scancode_rx_if.master         kb
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // ---------------------------------------------------------------
   // Pin synchronizers and falling-edge detect
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q;
   logic                   clk_s;
   logic                   data_s;
   logic                   fe;

   assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0],  ps2_clk};
   assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
   assign clk_s       = clk_sync_q[SYNC_STAGES-1];
   assign data_s      = data_sync_q[SYNC_STAGES-1];
   // Previous synchronized sample was 1 and the current one is 0.
   assign fe          = clk_prev_q & ~clk_s;

   // ---------------------------------------------------------------
   // Frame FSM state
   // ---------------------------------------------------------------
   state_t           state_q,   state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q,   shift_d;
   logic             parity_q,  parity_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             done_q,    done_d;
   logic             good_q,    good_d;
   logic             timeout;

   // ---------------------------------------------------------------
   // Key-event stage
   // ---------------------------------------------------------------
   logic             ext_q,       ext_d;
   logic             brk_q,       brk_d;
   logic             newchar_q,   newchar_d;
   logic [15:0]      char_q,      char_d;
   logic             frame_err_q, frame_err_d;

   // Next-state logic of the frame FSM.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      done_d    = 1'b0;
      good_d    = good_q;
      timeout   = 1'b0;

      case (state_q)
         IDLE: begin
            // A high data bit on a fall is not a start bit; stay quiet.
            if (fe && !data_s) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (fe) begin
               shift_d[bit_cnt_q] = data_s;
               bit_cnt_d          = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fe) begin
               parity_d = data_s;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (fe) begin
               state_d = IDLE;
               done_d  = 1'b1;
               // Odd parity: XOR of data and parity bit must be 1.
               good_d  = data_s & (^{shift_q, parity_q});
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Stalled partial frame: abandon it and report an error.
      if ((state_q != IDLE) && !fe && (tmo_cnt_q == TMO_LAST)) begin
         state_d = IDLE;
         timeout = 1'b1;
      end
   end

   // Timeout counter: cleared on every fall and while idle, otherwise counts.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (fe || (state_d == IDLE)) begin
         tmo_cnt_d = '0;
      end else if (state_q != IDLE) begin
         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
   end

   // Byte interpretation, one cycle after the stop-bit fall.
   // done_q only occurs while the FSM is idle, so it can never coincide
   // with a timeout and newchar/frame_err stay mutually exclusive.
   always_comb begin
      ext_d       = ext_q;
      brk_d       = brk_q;
      char_d      = char_q;
      newchar_d   = 1'b0;
      frame_err_d = timeout;

      if (timeout) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end

      if (done_q) begin
         if (!good_q) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            // Break wins over extended so E0 F0 xx reports F0xx.
            char_d    = {(brk_q ? 8'hF0 : (ext_q ? 8'hE0 : 8'h00)), shift_q};
            newchar_d = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         tmo_cnt_q   <= '0;
         done_q      <= 1'b0;
         good_q      <= 1'b0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         newchar_q   <= 1'b0;
         char_q      <= 16'h0000;
         frame_err_q <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_cnt_q   <= tmo_cnt_d;
         done_q      <= done_d;
         good_q      <= good_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         newchar_q   <= newchar_d;
         char_q      <= char_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign kb.newchar   = newchar_q;
   assign kb.char      = char_q;
   assign kb.frame_err = frame_err_q;

endmodule
